// File: rtl/gf2m_digit_serial_mul_pkg.sv
// gf2m_defs: shared field constants, digit-count helper and FSM encoding
// for the digit-serial GF(2^M) multiplier.
package gf2m_defs;

    localparam int          M13    = 13;
    localparam int          D13    = 4;
    localparam logic [13:0] POLY13 = 14'h201B;
    localparam int          M11    = 11;
    localparam int          D11    = 4;
    localparam logic [11:0] POLY11 = 12'h805;
    localparam int          M8     = 8;
    localparam int          D8     = 4;
    localparam logic [8:0]  POLY8  = 9'h11B;

    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf2m_digit_serial_mul_step.sv
// gf2m_digit_step: one digit-serial step, nxt = (acc * x^D + a * digit) mod f,
// built from bit-wise shift-and-reduce stages only (XOR logic, no carries).
module gf2m_digit_step #(
    parameter int         M    = 13,
    parameter int         D    = 4,
    parameter logic [M:0] POLY = 14'h201B
) (
    input  logic [M-1:0] acc,
    input  logic [M-1:0] a,
    input  logic [D-1:0] digit,
    output logic [M-1:0] nxt
);

    logic [M-1:0] s;
    logic [M-1:0] p;
    logic [M-1:0] t;

    always_comb begin
        s = acc;
        p = '0;
        t = a;
        for (int i = 0; i < D; i++) begin
            s = {s[M-2:0], 1'b0} ^ (s[M-1] ? POLY[M-1:0] : '0);
            p = p ^ (digit[i] ? t : '0);
            t = {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY[M-1:0] : '0);
        end
        nxt = s ^ p;
    end

endmodule

// File: rtl/gf2m_digit_serial_mul.sv
// gf2m_digit_serial_mul: multi-cycle digit-serial GF(2^M) multiply(-accumulate),
// r = a*b (+ c) mod f, one op in flight with a start/done handshake.
module gf2m_digit_serial_mul
    import gf2m_defs::*;
#(
    parameter int         M    = 13,
    parameter int         D    = 4,
    parameter logic [M:0] POLY = 14'h201B
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start_i,
    input  logic         mac_i,
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    input  logic [M-1:0] c_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [M-1:0] r_o
);

    localparam int N  = ceil_div(M, D);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t          state;
    state_t          nxt_state;
    logic [M-1:0]    a_q;
    logic [N*D-1:0]  b_q;
    logic [M-1:0]    c_q;
    logic            mac_q;
    logic [M-1:0]    acc;
    logic [M-1:0]    step;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;

    assign ready_o = (state != RUN);
    assign done_o  = (state == DONE);
    assign accept  = start_i && ready_o;
    assign last    = (state == RUN) && (cnt == CW'(N - 1));

    // b is shifted left each step so the current MSD always sits at the top
    gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
        .acc  (acc),
        .a    (a_q),
        .digit(b_q[N*D-1 -: D]),
        .nxt  (step)
    );

    always_comb begin
        nxt_state = state;
        if (state == RUN)
            nxt_state = last ? DONE : RUN;
        else if (accept)
            nxt_state = RUN;
        else if (state == DONE)
            nxt_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            mac_q <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            r_o   <= '0;
        end else begin
            state <= nxt_state;
            if (accept) begin
                a_q   <= a_i;
                b_q   <= (N*D)'(b_i);
                c_q   <= c_i;
                mac_q <= mac_i;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc <= step;
                b_q <= b_q << D;
                cnt <= cnt + 1'b1;
                if (last)
                    r_o <= step ^ (mac_q ? c_q : '0);
            end
        end
    end

endmodule
